// File: rtl/frame_sequencer_pkg.sv
// ============================================================================
// Module      : game_seq_pkg
// Description : Shared types and constants for the frame sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_seq_pkg;

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_UPDATE = 2'd2,
        S_DRAW   = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_UPDATE = 4;
    localparam int DEF_NUM_LAYERS = 3;

    localparam int LAYER_MAP     = 0;
    localparam int LAYER_LINK    = 1;
    localparam int LAYER_ENEMIES = 2;

    localparam int UPD_GEN_MOVE      = 0;
    localparam int UPD_CHECK_COLLIDE = 1;
    localparam int UPD_LINK_ACTION   = 2;
    localparam int UPD_MOVE_ENEMIES  = 3;

    // Index width that stays legal when a count of one is configured.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/frame_sequencer_if.sv
// ============================================================================
// Module      : frame_sequencer_if
// Description : Timer/datapath-facing bundle of the frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface frame_sequencer_if
    import game_seq_pkg::*;
#(
    parameter int NUM_UPDATE  = DEF_NUM_UPDATE,
    parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
    parameter int FRAME_CNT_W = 16
);
    logic                   frame_tick;
    logic                   pause;
    logic [NUM_LAYERS-1:0]  layer_mask;
    logic [NUM_LAYERS-1:0]  draw_done;
    logic                   init;
    logic                   idle;
    logic [NUM_UPDATE-1:0]  update_en;
    logic [NUM_LAYERS-1:0]  draw_en;
    logic [FRAME_CNT_W-1:0] frame_count;
    logic [NUM_LAYERS-1:0]  draw_timeout_err;

    modport master (
        input  frame_tick, pause, layer_mask, draw_done,
        output init, idle, update_en, draw_en, frame_count, draw_timeout_err
    );

    modport slave (
        output frame_tick, pause, layer_mask, draw_done,
        input  init, idle, update_en, draw_en, frame_count, draw_timeout_err
    );
endinterface

`default_nettype wire

// File: rtl/frame_sequencer_layer_picker.sv
// ============================================================================
// Module      : seq_layer_picker
// Description : Finds the lowest enabled layer, either from index 0 or above
//               the current layer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_layer_picker
    import game_seq_pkg::*;
#(
    parameter  int NUM_LAYERS = DEF_NUM_LAYERS,
    localparam int LAYER_W    = idx_w(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0] layer_mask_i,
    input  logic [LAYER_W-1:0]    cur_idx_i,
    input  logic                  from_start_i,
    output logic [LAYER_W-1:0]    next_idx_o,
    output logic                  none_left_o
);

    // Scan downward so the last hit, i.e. the lowest qualifying index, wins.
    always_comb begin
        next_idx_o  = '0;
        none_left_o = 1'b1;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (layer_mask_i[i] && (from_start_i || (LAYER_W'(i) > cur_idx_i))) begin
                next_idx_o  = LAYER_W'(i);
                none_left_o = 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/frame_sequencer.sv
// ============================================================================
// Module      : frame_sequencer
// Description : Game-loop sequencer: tick wait, update phases, draw layers.
//               Optional draw watchdog enabled by SEQ_DRAW_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_sequencer
    import game_seq_pkg::*;
#(
    parameter int NUM_UPDATE  = DEF_NUM_UPDATE,
    parameter int NUM_LAYERS  = DEF_NUM_LAYERS,
    parameter int FRAME_CNT_W = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input logic                clk_i,
    input logic                rst_i,
    frame_sequencer_if.master  bus
);

    localparam int STEP_W  = idx_w(NUM_UPDATE);
    localparam int LAYER_W = idx_w(NUM_LAYERS);

    localparam logic [1:0] ST_INIT   = S_INIT;
    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_UPDATE = S_UPDATE;
    localparam logic [1:0] ST_DRAW   = S_DRAW;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_UPDATE - 1);

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cyc
        $error("TIMEOUT_CYC must be at least 1");
    end

    logic [1:0]             state_q, state_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [LAYER_W-1:0]     layer_q, layer_d;
    logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

    logic                   w_from_start;
    logic                   w_none_left;
    logic [LAYER_W-1:0]     w_next_layer;
    logic                   w_timeout;
    logic                   w_layer_fin;

    assign w_from_start = (state_q != ST_DRAW);
    assign w_layer_fin  = bus.draw_done[layer_q] | w_timeout;

    seq_layer_picker #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_picker (
        .layer_mask_i (bus.layer_mask),
        .cur_idx_i    (layer_q),
        .from_start_i (w_from_start),
        .next_idx_o   (w_next_layer),
        .none_left_o  (w_none_left)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        layer_d = layer_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_INIT: begin
                state_d = w_none_left ? ST_IDLE : ST_DRAW;
                layer_d = w_next_layer;
            end
            ST_IDLE: begin
                if (bus.frame_tick && !bus.pause) begin
                    state_d = ST_UPDATE;
                    step_d  = '0;
                end
            end
            ST_UPDATE: begin
                if (step_q == LAST_STEP) begin
                    if (w_none_left) begin
                        state_d = ST_IDLE;
                        fcnt_d  = fcnt_q + 1'b1;
                    end else begin
                        state_d = ST_DRAW;
                        layer_d = w_next_layer;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            default: begin
                if (w_layer_fin) begin
                    if (w_none_left) begin
                        state_d = ST_IDLE;
                        fcnt_d  = fcnt_q + 1'b1;
                    end else begin
                        layer_d = w_next_layer;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            step_q  <= '0;
            layer_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            layer_q <= layer_d;
            fcnt_q  <= fcnt_d;
        end
    end

`ifdef SEQ_DRAW_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0]      wdog_q;
    logic [NUM_LAYERS-1:0] err_q;

    // A done in the expiry cycle wins, so no flag is raised for that layer.
    assign w_timeout = (state_q == ST_DRAW) && !bus.draw_done[layer_q] &&
                       (wdog_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wdog_q <= '0;
            err_q  <= '0;
        end else begin
            wdog_q <= ((state_q == ST_DRAW) && !w_layer_fin) ? wdog_q + 1'b1 : '0;
            if (w_timeout) begin
                err_q[layer_q] <= 1'b1;
            end
        end
    end

    assign bus.draw_timeout_err = err_q;
`else
    assign w_timeout            = 1'b0;
    assign bus.draw_timeout_err = '0;
`endif

    assign bus.init        = (state_q == ST_INIT);
    assign bus.idle        = (state_q == ST_IDLE);
    assign bus.update_en   = (state_q == ST_UPDATE) ? (NUM_UPDATE'(1) << step_q) : '0;
    assign bus.draw_en     = (state_q == ST_DRAW) ? (NUM_LAYERS'(1) << layer_q) : '0;
    assign bus.frame_count = fcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_sequencer.sv
// ============================================================================
// Module      : tb_frame_sequencer
// Description : Directed scoreboard bench for frame_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frame_sequencer;
    import game_seq_pkg::*;

    typedef struct packed {
        logic        init;
        logic        idle;
        logic [3:0]  upd;
        logic [2:0]  draw;
        logic [15:0] fc;
        logic [2:0]  err;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    frame_sequencer_if #(.NUM_UPDATE(4), .NUM_LAYERS(3), .FRAME_CNT_W(16)) bus ();

    frame_sequencer #(
        .NUM_UPDATE  (4),
        .NUM_LAYERS  (3),
        .FRAME_CNT_W (16),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    obs_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_fc;
    logic [2:0]  exp_err;

    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.init, bus.idle, bus.update_en, bus.draw_en,
                     bus.frame_count, bus.draw_timeout_err};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs @%0t: got init=%b idle=%b upd=%b draw=%b fc=%0d err=%b, exp init=%b idle=%b upd=%b draw=%b fc=%0d err=%b",
                             $time, a.init, a.idle, a.upd, a.draw, a.fc, a.err,
                             e.init, e.idle, e.upd, e.draw, e.fc, e.err);
                end
            end
        end
    end

    task automatic chk(input string what, input logic ei, input logic eid,
                       input logic [2:0] ed, input logic [15:0] efc,
                       input logic [2:0] ee);
        checks++;
        if ({bus.init, bus.idle, bus.draw_en, bus.frame_count, bus.draw_timeout_err} !==
            {ei, eid, ed, efc, ee}) begin
            errors++;
            $display("FAIL %s @%0t: got init=%b idle=%b draw=%b fc=%0d err=%b, exp init=%b idle=%b draw=%b fc=%0d err=%b",
                     what, $time, bus.init, bus.idle, bus.draw_en, bus.frame_count,
                     bus.draw_timeout_err, ei, eid, ed, efc, ee);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic cyc(input logic tk, input logic ps, input logic [2:0] mk,
                       input logic [2:0] dn, input logic ei, input logic eid,
                       input logic [3:0] eu, input logic [2:0] ed);
        bus.frame_tick = tk;
        bus.pause      = ps;
        bus.layer_mask = mk;
        bus.draw_done  = dn;
        exp_q.push_back({ei, eid, eu, ed, exp_fc, exp_err});
        @(posedge clk);
        #1;
    endtask

    task automatic idle_c(input logic tk, input logic ps, input logic [2:0] mk);
        cyc(tk, ps, mk, 3'b000, 1'b0, 1'b1, 4'b0000, 3'b000);
    endtask

    task automatic draw_c(input logic [2:0] mk, input logic [2:0] dn, input logic [2:0] ed);
        cyc(1'b0, 1'b0, mk, dn, 1'b0, 1'b0, 4'b0000, ed);
    endtask

    task automatic upds(input logic [2:0] mk);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, mk, 3'b000, 1'b0, 1'b0, 4'(1 << i), 3'b000);
        end
    endtask

    initial begin : stim
        rst            = 1'b1;
        bus.frame_tick = 1'b0;
        bus.pause      = 1'b0;
        bus.layer_mask = 3'b111;
        bus.draw_done  = 3'b000;
        exp_fc         = 16'd0;
        exp_err        = 3'b000;
        @(posedge clk);
        #1;

        // Reset state, then the first frame draws without updates.
        cyc(1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 4'b0000, 3'b000);
        chk("reset state", 1'b1, 1'b0, 3'b000, 16'd0, 3'b000);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 4'b0000, 3'b000);
        draw_c(3'b111, 3'b000, 3'b001);
        draw_c(3'b111, 3'b001, 3'b001);
        draw_c(3'b111, 3'b001, 3'b010);
        draw_c(3'b111, 3'b010, 3'b010);
        draw_c(3'b111, 3'b100, 3'b100);
        exp_fc = 16'd1;
        idle_c(1'b0, 1'b0, 3'b111);

        // Full frame, every layer done in its first cycle.
        idle_c(1'b1, 1'b0, 3'b111);
        upds(3'b111);
        draw_c(3'b111, 3'b001, 3'b001);
        draw_c(3'b111, 3'b010, 3'b010);
        draw_c(3'b111, 3'b100, 3'b100);
        exp_fc = 16'd2;

        // Link layer masked off.
        idle_c(1'b1, 1'b0, 3'b101);
        upds(3'b101);
        draw_c(3'b101, 3'b001, 3'b001);
        draw_c(3'b101, 3'b100, 3'b100);
        exp_fc = 16'd3;

        // No layers: updates go straight back to idle.
        idle_c(1'b1, 1'b0, 3'b000);
        upds(3'b000);
        exp_fc = 16'd4;

        // Ticks while paused are dropped.
        idle_c(1'b1, 1'b1, 3'b111);
        idle_c(1'b0, 1'b1, 3'b111);
        idle_c(1'b1, 1'b1, 3'b111);
        idle_c(1'b1, 1'b1, 3'b111);
        idle_c(1'b0, 1'b0, 3'b111);
        idle_c(1'b0, 1'b0, 3'b111);

        // Reset during the link layer aborts at once.
        idle_c(1'b1, 1'b0, 3'b111);
        upds(3'b111);
        draw_c(3'b111, 3'b001, 3'b001);
        draw_c(3'b111, 3'b000, 3'b010);
        rst    = 1'b1;
        exp_fc = 16'd0;
        cyc(1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 4'b0000, 3'b000);
        chk("mid-frame reset", 1'b1, 1'b0, 3'b000, 16'd0, 3'b000);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0, 4'b0000, 3'b000);

        // Clearing the mask mid-draw finishes the current layer only.
        draw_c(3'b111, 3'b001, 3'b001);
        draw_c(3'b000, 3'b000, 3'b010);
        draw_c(3'b000, 3'b010, 3'b010);
        exp_fc = 16'd1;

        idle_c(1'b1, 1'b0, 3'b111);
        upds(3'b111);
        draw_c(3'b111, 3'b001, 3'b001);
`ifdef SEQ_DRAW_TIMEOUT_EN
        // Withheld done on link: abandoned after 8 cycles, flag is sticky.
        repeat (8) draw_c(3'b111, 3'b000, 3'b010);
        exp_err = 3'b010;
        chk("expired wait", 1'b0, 1'b0, 3'b100, 16'd1, 3'b010);
        draw_c(3'b111, 3'b100, 3'b100);
        exp_fc = 16'd2;
        idle_c(1'b1, 1'b0, 3'b111);
        upds(3'b111);
        draw_c(3'b111, 3'b001, 3'b001);
        draw_c(3'b111, 3'b010, 3'b010);
        // Done in the expiry cycle counts as done.
        repeat (7) draw_c(3'b111, 3'b000, 3'b100);
        draw_c(3'b111, 3'b100, 3'b100);
        exp_fc = 16'd3;
        idle_c(1'b0, 1'b0, 3'b111);
        chk("sticky flag", 1'b0, 1'b1, 3'b000, 16'd3, 3'b010);
`else
        // Without the watchdog a layer waits indefinitely for done.
        repeat (10) draw_c(3'b111, 3'b000, 3'b010);
        chk("unbounded wait", 1'b0, 1'b0, 3'b010, 16'd1, 3'b000);
        draw_c(3'b111, 3'b010, 3'b010);
        draw_c(3'b111, 3'b100, 3'b100);
        exp_fc = 16'd2;
        idle_c(1'b0, 1'b0, 3'b111);
`endif

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_sequencer.md
# frame_sequencer

Parametrised top-level game-loop sequencer that replaces the fixed nine-state game control FSM. It orders one frame as: wait for frame tick, then N single-cycle update phases, then M draw layers, each handshaked with the datapath. It adds pause, per-layer skip masking, a frame counter and an optional draw watchdog. It sits between the frame timer and the game datapath, driving its phase enables.

## Interface
- NUM_UPDATE, default 4: single-cycle update phases (default order: gen move, check collide, link action, move enemies).
- NUM_LAYERS, default 3: draw layers (default order: map, link, enemies).
- FRAME_CNT_W, default 16: frame counter width.
- TIMEOUT_CYC, default 65535: watchdog limit in cycles; used only with the macro; must be ≥1.
- clock  in  1  system clock (CLOCK_50).
- reset  in  1  asynchronous, active-high reset.
- frame_tick  in  1  frame timer pulse, sampled only in IDLE.
- pause  in  1  level; holds the sequencer in IDLE.
- layer_mask  in  NUM_LAYERS  1 = layer enabled.
- draw_done  in  NUM_LAYERS  per-layer done from the datapath.
- init  out  1  initialisation phase.
- idle  out  1  idle phase.
- update_en  out  NUM_UPDATE  one-hot update phase enable.
- draw_en  out  NUM_LAYERS  one-hot draw enable.
- frame_count  out  FRAME_CNT_W  completed frames.
- draw_timeout_err  out  NUM_LAYERS  sticky watchdog flags.

## Operation
- State register holds S_INIT, S_IDLE, S_UPDATE or S_DRAW, plus a step index (clog2 NUM_UPDATE) and a layer index (clog2 NUM_LAYERS).
- Outputs are Moore outputs, decoded from registered state only. At most one of init, idle, update_en, draw_en is active in any cycle.
- S_INIT: init=1 for one cycle. Then go to S_DRAW at the lowest enabled layer, or to S_IDLE if layer_mask==0. The first frame draws without an update.
- S_IDLE: idle=1. If frame_tick && !pause, go to S_UPDATE with step=0. A tick while paused is dropped, not queued.
- S_UPDATE: update_en[step]=1 for exactly one cycle per step. After step NUM_UPDATE-1, go to S_DRAW at the lowest enabled layer, or to S_IDLE if none.
- S_DRAW: draw_en[layer]=1 until draw_done[layer]=1. draw_done bits of other layers are ignored.
- On draw_done, select the next enabled layer with a higher index, or go to S_IDLE if none.
- layer_mask is sampled only when selecting a layer. Clearing a layer's mask bit mid-draw does not abort that layer.
- Entering S_IDLE from S_UPDATE or S_DRAW increments frame_count, wrapping modulo 2^FRAME_CNT_W. Leaving S_INIT does not increment it.
- pause has no effect outside S_IDLE. A frame in progress always completes.

## Timing
- Reset values while reset is asserted: state S_INIT, so init=1; idle=0, update_en=0, draw_en=0, frame_count=0, draw_timeout_err=0.
- Reset asserted mid-frame aborts immediately (asynchronous). The first cycle after deassertion is S_INIT.
- frame_tick high in cycle k (in IDLE, unpaused) gives update_en[0] in cycle k+1.
- update_en[NUM_UPDATE-1] in cycle j gives the first draw_en in cycle j+1.
- draw_done in cycle k gives the next draw_en, or idle, in cycle k+1. There is no bubble.
- Minimum frame length: 1 + NUM_UPDATE + sum of draw cycles. A draw layer whose done arrives in its first cycle costs 1 cycle.

## Configuration
- SEQ_DRAW_TIMEOUT_EN defined:
  - A per-layer cycle counter resets on entry to each draw layer.
  - If draw_en[layer] stays high for TIMEOUT_CYC cycles without done, the layer is abandoned exactly as if done had arrived, and draw_timeout_err[layer] sets.
  - The flag is sticky until reset.
  - done and timeout in the same cycle: treated as done, no flag set.
- SEQ_DRAW_TIMEOUT_EN undefined: the sequencer waits indefinitely for done; draw_timeout_err is tied to 0 and no counter is built.

## Structure
- Package game_seq_pkg holds:
  - the state enum (S_INIT, S_IDLE, S_UPDATE, S_DRAW);
  - default values of NUM_UPDATE and NUM_LAYERS;
  - named layer index constants LAYER_MAP=0, LAYER_LINK=1, LAYER_ENEMIES=2;
  - named update index constants UPD_GEN_MOVE=0 through UPD_MOVE_ENEMIES=3.
- Sub-module seq_layer_picker: combinational. Inputs are layer_mask and the current index, with a "from start" flag. Outputs are the next enabled index and a none-left flag.

## Test plan
- Reset, then release, with mask=3'b111: init for 1 cycle, then draw_en=001 until done[0], 010, 100, then idle; frame_count=0 before the final done and 1 after it.
- In IDLE, pulse frame_tick: update_en walks 0001, 0010, 0100, 1000 on consecutive cycles, then draw_en=001 on the next cycle.
- mask=3'b101: after updates, draw_en=001 then 100, skipping link. mask=0: updates are followed directly by idle, and frame_count still increments.
- pause=1 with 3 frame_ticks: stays idle, frame_count unchanged. Release pause with no tick: still idle.
- Assert reset during draw_en=010: init=1 and all other enables 0 immediately; frame_count=0.
- With SEQ_DRAW_TIMEOUT_EN and TIMEOUT_CYC=8: withhold done[1]. draw_en=010 lasts 8 cycles, then draw_en=100, and draw_timeout_err=010 stays set across later frames.
